// File: rtl/arbiter_4_sdp_rr.sv
// arbiter_4_sdp_rr: round-robin arbiter that shares one single-ported,
// dynamic-latency memory among four requesters using a go/done handshake.
// Each transaction's address, data and operation are latched at grant.
module arbiter_4_sdp_rr #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic [IDX_SIZE-1:0] addr1,
  input  logic [IDX_SIZE-1:0] addr2,
  input  logic [IDX_SIZE-1:0] addr3,
  input  logic [WIDTH-1:0]    in0,
  input  logic [WIDTH-1:0]    in1,
  input  logic [WIDTH-1:0]    in2,
  input  logic [WIDTH-1:0]    in3,
  input  logic                read_en0,
  input  logic                read_en1,
  input  logic                read_en2,
  input  logic                read_en3,
  input  logic                write_en0,
  input  logic                write_en1,
  input  logic                write_en2,
  input  logic                write_en3,
  output logic [WIDTH-1:0]    out0,
  output logic [WIDTH-1:0]    out1,
  output logic [WIDTH-1:0]    out2,
  output logic [WIDTH-1:0]    out3,
  output logic                read_done0,
  output logic                read_done1,
  output logic                read_done2,
  output logic                read_done3,
  output logic                write_done0,
  output logic                write_done1,
  output logic                write_done2,
  output logic                write_done3,
  output logic [IDX_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_in,
  output logic                mem_read_en,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_out,
  input  logic                mem_read_done,
  input  logic                mem_write_done
);

  localparam int unsigned NPORT = 4;
  localparam int unsigned PW    = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject configurations whose depth cannot be addressed
  if (SIZE > (32'd1 << IDX_SIZE)) begin : g_size_check
    $error("arbiter_4_sdp_rr: SIZE exceeds 2**IDX_SIZE");
  end

  logic [IDX_SIZE-1:0] addr_a     [NPORT];
  logic [WIDTH-1:0]    in_a       [NPORT];
  logic [WIDTH-1:0]    out_q      [NPORT];
  logic [NPORT-1:0]    read_en_a;
  logic [NPORT-1:0]    write_en_a;
  logic [NPORT-1:0]    req;
  logic [NPORT-1:0]    read_done_q;
  logic [NPORT-1:0]    write_done_q;

  logic [1:0]    state_q;
  logic [1:0]    state_nxt;
  logic [PW-1:0] last_q;
  logic [PW-1:0] g_q;
  logic          op_write_q;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          any_req;
  logic          grant_c;
  logic          complete_c;

  assign addr_a[0] = addr0;
  assign addr_a[1] = addr1;
  assign addr_a[2] = addr2;
  assign addr_a[3] = addr3;
  assign in_a[0]   = in0;
  assign in_a[1]   = in1;
  assign in_a[2]   = in2;
  assign in_a[3]   = in3;
  assign read_en_a  = {read_en3, read_en2, read_en1, read_en0};
  assign write_en_a = {write_en3, write_en2, write_en1, write_en0};
  assign req        = read_en_a | write_en_a;

  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];
  assign {read_done3, read_done2, read_done1, read_done0}     = read_done_q;
  assign {write_done3, write_done2, write_done1, write_done0} = write_done_q;

  // Round-robin pick: first requester after last, with last itself checked last
  always_comb begin
    any_req = |req;
    win     = last_q;
    cand    = last_q;
    for (int i = NPORT - 1; i >= 1; i--) begin
      cand = last_q + PW'(i);
      if (req[cand]) win = cand;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state and grant/completion strobes
  always_comb begin
    state_nxt  = state_q;
    grant_c    = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_c   = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (op_write_q ? mem_write_done : mem_read_done) begin
          complete_c = 1'b1;
          state_nxt  = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the granted transaction, drive memory, return data and done pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q       <= PW'(NPORT - 1);
      g_q          <= '0;
      op_write_q   <= 1'b0;
      mem_addr     <= '0;
      mem_in       <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      read_done_q  <= '0;
      write_done_q <= '0;
      for (int k = 0; k < NPORT; k++) out_q[k] <= '0;
    end else begin
      read_done_q  <= '0;
      write_done_q <= '0;
      if (grant_c) begin
        g_q          <= win;
        last_q       <= win;
        op_write_q   <= write_en_a[win];
        mem_addr     <= addr_a[win];
        mem_in       <= write_en_a[win] ? in_a[win] : '0;
        mem_read_en  <= ~write_en_a[win];
        mem_write_en <= write_en_a[win];
      end else if (complete_c) begin
        mem_addr     <= '0;
        mem_in       <= '0;
        mem_read_en  <= 1'b0;
        mem_write_en <= 1'b0;
        if (op_write_q) begin
          write_done_q[g_q] <= 1'b1;
        end else begin
          read_done_q[g_q] <= 1'b1;
          out_q[g_q]       <= mem_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_arbiter_4_sdp_rr.sv
// tb_arbiter_4_sdp_rr: directed bench for the four-port round-robin memory arbiter.
module tb_arbiter_4_sdp_rr;

  logic        clk;
  logic        reset;
  logic [3:0]  addr0, addr1, addr2, addr3;
  logic [31:0] in0, in1, in2, in3;
  logic        read_en0, read_en1, read_en2, read_en3;
  logic        write_en0, write_en1, write_en2, write_en3;
  logic [31:0] out0, out1, out2, out3;
  logic        read_done0, read_done1, read_done2, read_done3;
  logic        write_done0, write_done1, write_done2, write_done3;
  logic [3:0]  mem_addr;
  logic [31:0] mem_in;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_out;
  logic        mem_read_done, mem_write_done;

  int n_cmp = 0;
  int n_err = 0;

  arbiter_4_sdp_rr dut (
    .clk(clk), .reset(reset),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .read_en0(read_en0), .read_en1(read_en1), .read_en2(read_en2), .read_en3(read_en3),
    .write_en0(write_en0), .write_en1(write_en1), .write_en2(write_en2), .write_en3(write_en3),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .read_done0(read_done0), .read_done1(read_done1),
    .read_done2(read_done2), .read_done3(read_done3),
    .write_done0(write_done0), .write_done1(write_done1),
    .write_done2(write_done2), .write_done3(write_done3),
    .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_out(mem_out), .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
  );

  logic [3:0] rd_v, wr_v;
  assign rd_v = {read_done3, read_done2, read_done1, read_done0};
  assign wr_v = {write_done3, write_done2, write_done1, write_done0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_mem(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_read_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_write_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_in"}, mem_in, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    {addr0, addr1, addr2, addr3} = '0;
    {in0, in1, in2, in3} = '0;
    {read_en0, read_en1, read_en2, read_en3} = '0;
    {write_en0, write_en1, write_en2, write_en3} = '0;
    mem_out = '0; mem_read_done = 1'b0; mem_write_done = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out0", out0, 0); chk("rst_out1", out1, 0);
    chk("rst_out2", out2, 0); chk("rst_out3", out3, 0);
    chk("rst_rd_done", 32'(rd_v), 0); chk("rst_wr_done", 32'(wr_v), 0);
    chk_idle_mem("rst");

    // Single read on port 2, memory answers two cycles after enable rises
    read_en2 = 1'b1; addr2 = 4'd5;
    tick();
    chk("rd_en_t1", 32'(mem_read_en), 1); chk("rd_wr_en_t1", 32'(mem_write_en), 0);
    chk("rd_addr_t1", 32'(mem_addr), 5);
    addr2 = 4'd9;
    tick();
    chk("rd_addr_t2", 32'(mem_addr), 5); chk("rd_done_t2", 32'(rd_v), 0);
    tick();
    mem_read_done = 1'b1; mem_out = 32'hDEADBEEF;
    chk("rd_addr_t3", 32'(mem_addr), 5); chk("rd_en_t3", 32'(mem_read_en), 1);
    tick();
    mem_read_done = 1'b0; mem_out = '0;
    chk("rd_done2", 32'(rd_v), 32'b0100); chk("rd_out2", out2, 32'hDEADBEEF);
    chk_idle_mem("rd_donecyc");
    tick();
    read_en2 = 1'b0;
    chk("rd_done_clr", 32'(rd_v), 0); chk("rd_out2_held", out2, 32'hDEADBEEF);
    chk("rd_out0", out0, 0); chk("rd_out1", out1, 0); chk("rd_out3", out3, 0);

    // Single write on port 1 with a 0-wait strobe
    write_en1 = 1'b1; addr1 = 4'd3; in1 = 32'h12345678;
    tick();
    chk("wr_en", 32'(mem_write_en), 1); chk("wr_rd_en", 32'(mem_read_en), 0);
    chk("wr_in", mem_in, 32'h12345678); chk("wr_addr", 32'(mem_addr), 3);
    mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0;
    chk("wr_done1", 32'(wr_v), 32'b0010); chk("wr_rd_done", 32'(rd_v), 0);
    chk_idle_mem("wr_donecyc");
    chk("wr_out1", out1, 0); chk("wr_out2_held", out2, 32'hDEADBEEF);
    tick();
    write_en1 = 1'b0;
    chk("wr_done_clr", 32'(wr_v), 0);

    // Read/write conflict on port 0: write wins, read strobe ignored
    read_en0 = 1'b1; write_en0 = 1'b1; addr0 = 4'd7; in0 = 32'hA5A5A5A5;
    tick();
    chk("cf_wr_en", 32'(mem_write_en), 1); chk("cf_rd_en", 32'(mem_read_en), 0);
    chk("cf_in", mem_in, 32'hA5A5A5A5); chk("cf_addr", 32'(mem_addr), 7);
    mem_read_done = 1'b1; mem_out = 32'h11111111;
    tick();
    chk("cf_still_busy", 32'(mem_write_en), 1);
    chk("cf_no_rd_done", 32'(rd_v), 0); chk("cf_no_wr_done", 32'(wr_v), 0);
    mem_read_done = 1'b0; mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0; mem_out = '0;
    chk("cf_wr_done0", 32'(wr_v), 32'b0001); chk("cf_rd_done", 32'(rd_v), 0);
    chk("cf_out0", out0, 0);
    tick();
    read_en0 = 1'b0; write_en0 = 1'b0;
    chk("cf_done_clr", 32'(wr_v), 0);

    // Reset mid-transaction on port 3 (pointer is at 0, so 3 is found after 1,2)
    read_en3 = 1'b1; addr3 = 4'd2;
    tick();
    chk("rm_rd_en", 32'(mem_read_en), 1); chk("rm_addr", 32'(mem_addr), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0; read_en3 = 1'b0;
    mem_read_done = 1'b1; mem_out = 32'hFFFF0000;
    chk_idle_mem("rm_after");
    chk("rm_out2_cleared", out2, 0); chk("rm_no_done", 32'(rd_v), 0);
    tick();
    mem_read_done = 1'b0; mem_out = '0;
    chk("rm_stray_done", 32'(rd_v), 0); chk("rm_out3", out3, 0);
    chk_idle_mem("rm_stray");
    read_en0 = 1'b1; addr0 = 4'd1; read_en3 = 1'b1; addr3 = 4'd2;
    tick();
    chk("rm_grant0_addr", 32'(mem_addr), 1); chk("rm_grant0_en", 32'(mem_read_en), 1);
    mem_read_done = 1'b1; mem_out = 32'h0BADF00D;
    tick();
    mem_read_done = 1'b0; mem_out = '0;
    chk("rm_done0", 32'(rd_v), 32'b0001); chk("rm_out0", out0, 32'h0BADF00D);
    tick();
    read_en0 = 1'b0; read_en3 = 1'b0;

    // Fairness: all four ports request continuously from reset
    reset = 1'b1;
    read_en0 = 1'b1; read_en1 = 1'b1; read_en2 = 1'b1; read_en3 = 1'b1;
    addr0 = 4'd8; addr1 = 4'd9; addr2 = 4'd10; addr3 = 4'd11;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      logic [31:0] exp_out;
      logic [31:0] got_out;
      exp_out = 32'h100 + 32'(n);
      tick();
      chk("fr_busy_addr", 32'(mem_addr), 32'd8 + 32'(n % 4));
      chk("fr_busy_en", 32'(mem_read_en), 1);
      mem_read_done = 1'b1; mem_out = exp_out;
      tick();
      mem_read_done = 1'b0; mem_out = '0;
      chk("fr_done_onehot", 32'(rd_v), 32'd1 << (n % 4));
      case (n % 4)
        0: got_out = out0;
        1: got_out = out1;
        2: got_out = out2;
        default: got_out = out3;
      endcase
      chk("fr_out", got_out, exp_out);
      tick();
      chk("fr_idle_done", 32'(rd_v), 0);
    end
    read_en0 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0; read_en3 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter_4_sdp_rr.md
# arbiter_4_sdp_rr

Round-robin arbiter that shares one single-ported, dynamic-latency memory among four requesters using the go/done handshake of the Calyx memory primitives. It sits between four component-side memory ports and one memory-side port. Each transaction's address, write data and operation are registered at grant, so the memory sees stable inputs for the whole transaction. Each requester gets a one-cycle done pulse plus a held read-data register.

## Interface
- WIDTH, 32, data width
- SIZE, 16, memory depth (words)
- IDX_SIZE, 4, address width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- addrK (K=0..3)  input  IDX_SIZE  address for port K
- inK (K=0..3)  input  WIDTH  write data for port K
- read_enK (K=0..3)  input  1  read request, held high until read_doneK
- write_enK (K=0..3)  input  1  write request, held high until write_doneK
- outK (K=0..3)  output  WIDTH  last read data returned to port K (held)
- read_doneK / write_doneK (K=0..3)  output  1  one-cycle completion pulse for port K
- mem_addr  output  IDX_SIZE  registered address to memory
- mem_in  output  WIDTH  registered write data to memory
- mem_read_en / mem_write_en  output  1  memory request, high for all of BUSY
- mem_out  input  WIDTH  memory read data, valid with mem_read_done
- mem_read_done / mem_write_done  input  1  memory completion strobes

## Operation
- States:
  - IDLE: no transaction.
  - BUSY: a transaction is in flight for the granted port g.
  - DONE: one cycle, done pulse asserted.
- Request K = read_enK | write_enK. If both are high, the write wins; the read is not performed and no read_done is issued.
- Round-robin pointer `last` (2 bits) names the most recently granted port. Search order is last+1, last+2, last+3, last (mod 4); the first requesting port wins.
- IDLE with any request, at the clock edge:
  - g <= winner, last <= winner.
  - Latch op (write/read), addr_g and in_g (in_g only for a write).
  - Go to BUSY.
- IDLE with no request: remain in IDLE.
- BUSY:
  - mem_read_en = (op==read), mem_write_en = (op==write).
  - mem_addr and mem_in come from the latched registers. Requester inputs are ignored until DONE.
  - Completion is the memory strobe matching op. The other strobe is ignored.
  - On a read completion: out_g <= mem_out, read_done_g <= 1, go to DONE.
  - On a write completion: write_done_g <= 1, go to DONE.
  - BUSY with no matching strobe: stay in BUSY indefinitely. There is no timeout.
- DONE:
  - All memory enables are low.
  - The done pulse clears at the next edge.
  - Go to IDLE. Requests are not sampled in DONE.
- mem_read_done / mem_write_done arriving in IDLE or DONE: ignored, with no state change.
- outK changes only on a read completion for port K. It never changes on a write or on another port's read.
- Outside BUSY: mem_addr = 0, mem_in = 0, both enables low.

## Timing
- Reset: state=IDLE, last=3 (port 0 has first priority), g=0, latched addr/data=0.
- Reset values of outputs: all outK=0, all done outputs 0, mem_read_en=mem_write_en=0, mem_addr=0, mem_in=0.
- Reset during BUSY or DONE aborts the transaction on that edge. No done pulse is issued and outK is cleared. The memory enables drop in the cycle after the reset edge.
- Latency:
  - Request high in IDLE at cycle t gives mem enable high at t+1.
  - A matching strobe at cycle d ≥ t+1 gives the done pulse at d+1 and IDLE at d+2.
  - Minimum of 3 cycles from request to IDLE-ready; next grant no earlier than d+2.
- Requester protocol: the requester holds its enable through its done cycle and drops it the cycle after. A request still high in IDLE is treated as a new transaction.
- At most one done output is high in any cycle. The done pulse is exactly 1 cycle wide.

## Test plan
- Single read:
  - Stimulus: read_en2=1, addr2=5, memory answers mem_read_done=1 with mem_out=0xDEADBEEF two cycles after mem_read_en rises.
  - Response: mem_addr=5 throughout BUSY, read_done2 pulses once, out2=0xDEADBEEF and held afterwards, out0/1/3 stay 0.
- Single write:
  - Stimulus: write_en1=1, addr1=3, in1=0x12345678, with a 0-wait strobe.
  - Response: mem_write_en=1, mem_in=0x12345678, mem_addr=3 for one cycle, then write_done1 pulses.
- Fairness:
  - Stimulus: all four ports request continuously from reset.
  - Response: grants occur in order 0,1,2,3,0,…, each port receives exactly one done in every 4 transactions, and done pulses are never concurrent.
- Read/write conflict and wrong strobe:
  - Stimulus: port 0 drives read_en0=write_en0=1; the memory first raises mem_read_done, then mem_write_done.
  - Response: a write is performed, the read strobe is ignored, and only write_done0 pulses, on the cycle after mem_write_done.
- Reset mid-transaction:
  - Stimulus: port 3 granted and BUSY, then reset=1 for one cycle, then a mem_read_done arrives.
  - Response: IDLE after reset, no read_done3, out3=0, the stray strobe is ignored, and a subsequent request from port 0 is granted first.
